// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Moves a sprite by updating signed row/column offsets once every FRAME_DIV
//   frame ticks. In manual mode the synchronized buttons steer the sprite; in
//   auto mode it travels diagonally and bounces off the configured bounds.
//
// Ports
//   clk           single clock, all state changes on its rising edge
//   reset         asynchronous active-high reset
//   frame_tick    one-cycle pulse at start of vertical blank
//   mode          0 = manual (buttons), 1 = auto bounce
//   btn[3:0]      raw async buttons: [0] up, [1] down, [2] left, [3] right
//   row_offset    signed 11-bit row offset to the sprite ROM
//   column_offset signed 11-bit column offset to the sprite ROM
//   step_done     one-cycle pulse in the cycle new offsets become visible
//   dir[1:0]      auto direction: [0] row, [1] column (0 = +, 1 = -)
module sprite_motion_ctrl #(
  parameter int SPEED     = 1,
  parameter int FRAME_DIV = 2,
  parameter int ROW_MIN   = -100,
  parameter int ROW_MAX   = 378,
  parameter int COL_MIN   = -100,
  parameter int COL_MAX   = 538
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        mode,
  input  logic [3:0]  btn,
  output logic [10:0] row_offset,
  output logic [10:0] column_offset,
  output logic        step_done,
  output logic [1:0]  dir
);

  localparam logic signed [11:0] STEP   = 12'(SPEED);
  localparam logic signed [11:0] ROW_LO = 12'(ROW_MIN);
  localparam logic signed [11:0] ROW_HI = 12'(ROW_MAX);
  localparam logic signed [11:0] COL_LO = 12'(COL_MIN);
  localparam logic signed [11:0] COL_HI = 12'(COL_MAX);
  localparam logic [7:0]         LAST_COUNT = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_CALC   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  btn_meta_reg, btn_sync_reg;
  logic [7:0]  frame_cnt_reg;
  logic        count_en, calc_en, commit_en, qualifying;
  logic [10:0] row_reg, col_reg, row_cand_reg, col_cand_reg;
  logic [1:0]  dir_reg, dir_cand_reg;
  logic        step_done_reg;
  logic [11:0] row_step, col_step;

  // One axis of motion. Returns {toggle, new_offset}. The sum is formed in
  // 12 bits so that an 11-bit offset plus SPEED cannot wrap before clamping.
  function automatic logic [11:0] axis_step(
    input logic [10:0]        cur,
    input logic               dec,
    input logic               inc,
    input logic               auto_mode,
    input logic               dir_bit,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    logic signed [11:0] delta;
    logic signed [11:0] cand;
    logic               toggle;
    logic [10:0]        value;
    delta = '0;
    if (auto_mode) begin
      delta = dir_bit ? -STEP : STEP;
    end else if (inc && !dec) begin
      delta = STEP;
    end else if (dec && !inc) begin
      delta = -STEP;
    end
    cand   = $signed({cur[10], cur}) + delta;
    toggle = 1'b0;
    value  = cand[10:0];
    if (auto_mode) begin
      // Reaching a bound exactly also counts as a bounce.
      if (cand >= hi) begin
        value  = hi[10:0];
        toggle = 1'b1;
      end else if (cand <= lo) begin
        value  = lo[10:0];
        toggle = 1'b1;
      end
    end else begin
      if (cand > hi) begin
        value = hi[10:0];
      end else if (cand < lo) begin
        value = lo[10:0];
      end
    end
    return {toggle, value};
  endfunction

  // Two-flop synchronizer per button bit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          btn_meta_reg[gi] <= 1'b0;
          btn_sync_reg[gi] <= 1'b0;
        end else begin
          btn_meta_reg[gi] <= btn[gi];
          btn_sync_reg[gi] <= btn_meta_reg[gi];
        end
      end
    end
  endgenerate

  assign qualifying = frame_tick && (frame_cnt_reg == LAST_COUNT);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_WAIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT:   if (qualifying) state_next = ST_CALC;
      ST_CALC:   state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_WAIT;
      default:   state_next = ST_WAIT;
    endcase
  end

  // FSM: outputs. Ticks outside WAIT are dropped so they never advance the count.
  always_comb begin
    count_en  = 1'b0;
    calc_en   = 1'b0;
    commit_en = 1'b0;
    case (state_reg)
      ST_WAIT:   count_en  = frame_tick;
      ST_CALC:   calc_en   = 1'b1;
      ST_COMMIT: commit_en = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if (count_en) begin
      frame_cnt_reg <= qualifying ? 8'd0 : frame_cnt_reg + 8'd1;
    end
  end

  always_comb begin
    row_step = axis_step(row_reg, btn_sync_reg[0], btn_sync_reg[1], mode,
                         dir_reg[0], ROW_LO, ROW_HI);
    col_step = axis_step(col_reg, btn_sync_reg[2], btn_sync_reg[3], mode,
                         dir_reg[1], COL_LO, COL_HI);
  end

  // Candidates are captured in CALC (mode sampled there) and published on
  // the COMMIT edge, so step_done and the new offsets appear together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cand_reg  <= '0;
      col_cand_reg  <= '0;
      dir_cand_reg  <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      dir_reg       <= '0;
      step_done_reg <= 1'b0;
    end else begin
      step_done_reg <= commit_en;
      if (calc_en) begin
        row_cand_reg <= row_step[10:0];
        col_cand_reg <= col_step[10:0];
        dir_cand_reg <= dir_reg ^ {col_step[11], row_step[11]};
      end
      if (commit_en) begin
        row_reg <= row_cand_reg;
        col_reg <= col_cand_reg;
        dir_reg <= dir_cand_reg;
      end
    end
  end

  assign row_offset    = row_reg;
  assign column_offset = col_reg;
  assign dir           = dir_reg;
  assign step_done     = step_done_reg;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Testbench for sprite_motion_ctrl. Three instances:
//   0: defaults, 1: SPEED = 4, 2: FRAME_DIV = 1.
// A behavioural model predicts offsets/dir/step_done; every cycle the DUT
// outputs are compared to it, and literal pins anchor key results.
module tb_sprite_motion_ctrl;

  localparam int RMIN = -100;
  localparam int RMAX = 378;
  localparam int CMIN = -100;
  localparam int CMAX = 538;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        tick [3];
  logic        mode [3];
  logic [3:0]  btn  [3];
  logic [10:0] row  [3];
  logic [10:0] col  [3];
  logic        sd   [3];
  logic [1:0]  dir  [3];

  sprite_motion_ctrl u_dut0 (
    .clk(clk), .reset(rst[0]), .frame_tick(tick[0]), .mode(mode[0]), .btn(btn[0]),
    .row_offset(row[0]), .column_offset(col[0]), .step_done(sd[0]), .dir(dir[0])
  );

  sprite_motion_ctrl #(.SPEED(4)) u_dut1 (
    .clk(clk), .reset(rst[1]), .frame_tick(tick[1]), .mode(mode[1]), .btn(btn[1]),
    .row_offset(row[1]), .column_offset(col[1]), .step_done(sd[1]), .dir(dir[1])
  );

  sprite_motion_ctrl #(.FRAME_DIV(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .frame_tick(tick[2]), .mode(mode[2]), .btn(btn[2]),
    .row_offset(row[2]), .column_offset(col[2]), .step_done(sd[2]), .dir(dir[2])
  );

  function automatic int spd_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic int fdiv_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Where the sprite goes on one step, straight from the motion rules.
  task automatic predict(input int i, input logic md, input logic [3:0] b,
                         input int r, input int c, input logic [1:0] d,
                         output int nr, output int nc, output logic [1:0] nd);
    int s;
    s  = spd_of(i);
    nd = d;
    if (md) begin
      nr = d[0] ? r - s : r + s;
      if (nr >= RMAX) begin nr = RMAX; nd[0] = ~d[0]; end
      else if (nr <= RMIN) begin nr = RMIN; nd[0] = ~d[0]; end
      nc = d[1] ? c - s : c + s;
      if (nc >= CMAX) begin nc = CMAX; nd[1] = ~d[1]; end
      else if (nc <= CMIN) begin nc = CMIN; nd[1] = ~d[1]; end
    end else begin
      nr = r;
      if (b[1] && !b[0]) nr = r + s;
      if (b[0] && !b[1]) nr = r - s;
      nc = c;
      if (b[3] && !b[2]) nc = c + s;
      if (b[2] && !b[3]) nc = c - s;
      nr = clampi(nr, RMIN, RMAX);
      nc = clampi(nc, CMIN, CMAX);
    end
  endtask

  typedef struct {
    int         row;
    int         col;
    logic [1:0] dir;
    logic       done;
    int         ticks_seen;
    int         busy;        // cycles until a pending step appears
    int         prow;
    int         pcol;
    logic [1:0] pdir;
  } mdl_t;

  mdl_t       m [3];
  int         mr, mc;
  logic [1:0] mdn;

  // Model timing: a step is requested by every FRAME_DIV-th accepted tick,
  // becomes visible two edges later, and ticks during that wait are dropped.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m[i] = '{default: 0};
      end else begin
        m[i].done = 1'b0;
        if (m[i].busy > 0) begin
          m[i].busy = m[i].busy - 1;
          if (m[i].busy == 0) begin
            m[i].row  = m[i].prow;
            m[i].col  = m[i].pcol;
            m[i].dir  = m[i].pdir;
            m[i].done = 1'b1;
          end
        end else if (tick[i]) begin
          m[i].ticks_seen = m[i].ticks_seen + 1;
          if (m[i].ticks_seen == fdiv_of(i)) begin
            m[i].ticks_seen = 0;
            m[i].busy = 2;
            predict(i, mode[i], btn[i], m[i].row, m[i].col, m[i].dir, mr, mc, mdn);
            m[i].prow = mr;
            m[i].pcol = mc;
            m[i].pdir = mdn;
          end
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int sd_cnt [3] = '{0, 0, 0};

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic pin(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    check(name, idx, act, exp);
    if (act === exp) $display("txn %s[%0d] value=0x%0h ok", name, idx, act);
  endtask

  // Per-cycle comparison of every instance against the model.
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [10:0] er, ec;
      logic [1:0]  ed;
      logic        es;
      er = rst[i] ? 11'd0 : 11'(m[i].row);
      ec = rst[i] ? 11'd0 : 11'(m[i].col);
      ed = rst[i] ? 2'd0  : m[i].dir;
      es = rst[i] ? 1'b0  : m[i].done;
      check("row_offset",    i, 32'(row[i]), 32'(er));
      check("column_offset", i, 32'(col[i]), 32'(ec));
      check("dir",           i, 32'(dir[i]), 32'(ed));
      check("step_done",     i, 32'(sd[i]),  32'(es));
      if (sd[i]) sd_cnt[i] = sd_cnt[i] + 1;
    end
  endtask

  // One clock: compare on the falling edge, then drive just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i);
    tick[i] = 1'b1;
    cyc();
    tick[i] = 1'b0;
  endtask

  task automatic ticks(input int i, input int n);
    repeat (n) begin
      pulse(i);
      repeat (3) cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  int base;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; tick[i] = 1'b0; mode[i] = 1'b0; btn[i] = 4'b0000;
    end
    mode[0] = 1'b1;
    mode[1] = 1'b1;
    btn[2]  = 4'b0001;
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      pin("reset_row", i, 32'(row[i]), 32'd0);
      pin("reset_col", i, 32'(col[i]), 32'd0);
      pin("reset_dir", i, 32'(dir[i]), 32'd0);
      pin("reset_sd",  i, 32'(sd[i]),  32'd0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    repeat (4) cyc();

    // Auto, defaults: the first tick only counts; the second commits two edges later.
    pulse(0);
    repeat (3) cyc();
    pin("first_tick_no_step", 0, 32'(sd_cnt[0]), 32'd0);
    pulse(0);
    pin("calc_sd",  0, 32'(sd[0]),  32'd0);
    pin("calc_row", 0, 32'(row[0]), 32'd0);
    cyc();
    pin("commit_sd",  0, 32'(sd[0]),  32'd0);
    pin("commit_row", 0, 32'(row[0]), 32'd0);
    cyc();
    pin("visible_sd",  0, 32'(sd[0]),  32'd1);
    pin("visible_row", 0, 32'(row[0]), 32'd1);
    pin("visible_col", 0, 32'(col[0]), 32'd1);
    pin("visible_dir", 0, 32'(dir[0]), 32'd0);
    cyc();
    pin("sd_one_cycle", 0, 32'(sd[0]), 32'd0);

    // Tick held high: ticks inside a step are dropped, one step per 4 cycles.
    base = sd_cnt[0];
    tick[0] = 1'b1;
    repeat (12) cyc();
    tick[0] = 1'b0;
    repeat (4) cyc();
    pin("held_tick_steps", 0, 32'(sd_cnt[0] - base), 32'd3);
    pin("held_tick_row",   0, 32'(row[0]), 32'd4);

    // Manual, opposing buttons: no motion but step_done still pulses.
    rst[0] = 1'b1;
    cyc();
    rst[0]  = 1'b0;
    mode[0] = 1'b0;
    btn[0]  = 4'b0011;
    repeat (4) cyc();
    base = sd_cnt[0];
    ticks(0, 10);
    pin("updown_steps", 0, 32'(sd_cnt[0] - base), 32'd5);
    pin("updown_row",   0, 32'(row[0]), 32'd0);
    btn[0] = 4'b1100;
    repeat (4) cyc();
    base = sd_cnt[0];
    ticks(0, 10);
    pin("leftright_steps", 0, 32'(sd_cnt[0] - base), 32'd5);
    pin("leftright_col",   0, 32'(col[0]), 32'd0);

    // Manual single directions, then auto picks up from there.
    btn[0] = 4'b0010;
    repeat (4) cyc();
    ticks(0, 4);
    pin("down_row", 0, 32'(row[0]), 32'd2);
    btn[0] = 4'b1000;
    repeat (4) cyc();
    ticks(0, 6);
    pin("right_col", 0, 32'(col[0]), 32'd3);
    btn[0] = 4'b0101;
    repeat (4) cyc();
    ticks(0, 2);
    pin("upleft_row", 0, 32'(row[0]), 32'd1);
    pin("upleft_col", 0, 32'(col[0]), 32'd2);
    mode[0] = 1'b1;
    btn[0]  = 4'b0000;
    repeat (4) cyc();
    ticks(0, 2);
    pin("auto_row", 0, 32'(row[0]), 32'd2);
    pin("auto_col", 0, 32'(col[0]), 32'd3);

    // Reset during CALC aborts the step.
    ticks(0, 1);
    pulse(0);
    rst[0] = 1'b1;
    #1;
    pin("abort_row", 0, 32'(row[0]), 32'd0);
    pin("abort_col", 0, 32'(col[0]), 32'd0);
    pin("abort_sd",  0, 32'(sd[0]),  32'd0);
    base = sd_cnt[0];
    repeat (4) cyc();
    pin("abort_no_step", 0, 32'(sd_cnt[0] - base), 32'd0);
    rst[0] = 1'b0;
    repeat (2) cyc();
    ticks(0, 1);
    pin("after_abort_one_tick", 0, 32'(row[0]), 32'd0);
    ticks(0, 1);
    pin("after_abort_two_ticks", 0, 32'(row[0]), 32'd1);

    // SPEED = 4 auto bounce off ROW_MAX, then off ROW_MIN.
    ticks(1, 188);
    pin("pre_bounce_row", 1, 32'(row[1]), 32'd376);
    pin("pre_bounce_dir", 1, 32'(dir[1]), 32'd0);
    ticks(1, 2);
    pin("bounce_row", 1, 32'(row[1]), 32'd378);
    pin("bounce_dir", 1, 32'(dir[1]), 32'd1);
    ticks(1, 2);
    pin("after_bounce_row", 1, 32'(row[1]), 32'd374);
    pin("after_bounce_col", 1, 32'(col[1]), 32'd384);
    ticks(1, 238);
    pin("min_bounce_row", 1, 32'(row[1]), 32'h79C);
    pin("min_bounce_col", 1, 32'(col[1]), 32'd218);
    pin("min_bounce_dir", 1, 32'(dir[1]), 32'd2);

    // FRAME_DIV = 1, up held from reset: clamps at ROW_MIN and stays.
    ticks(2, 100);
    pin("clamp_row", 2, 32'(row[2]), 32'h79C);
    pin("clamp_col", 2, 32'(col[2]), 32'd0);
    ticks(2, 5);
    pin("clamp_hold_row", 2, 32'(row[2]), 32'h79C);
    pin("clamp_steps",    2, 32'(sd_cnt[2]), 32'd105);

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
